// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, ALU control codes, P bit indices and FSM states for alu_sequencer.
package alu_seq_pkg;
  localparam logic [2:0] OP_ADC = 3'd0;
  localparam logic [2:0] OP_SBC = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORA = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;
  localparam logic [2:0] OP_LSR = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;
  localparam logic [2:0] ALU_SUM = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SR  = 3'd4;
  localparam int P_NEG    = 7;
  localparam int P_OVF    = 6;
  localparam int P_UNUSED = 5;
  localparam int P_BREAK  = 4;
  localparam int P_BCD    = 3;
  localparam int P_IRQ    = 2;
  localparam int P_ZERO   = 1;
  localparam int P_CARRY  = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
endpackage

// File: rtl/alu_seq_flags.sv
// alu_seq_flags: combinational N/Z/V/C from the latched operands and the ALU result.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] bi,
  input  logic [7:0] y,
  input  logic       alu_c,
  output logic       n,
  output logic       z,
  output logic       v,
  output logic       c
);
  assign n = y[7];
  assign z = y == 8'h00;
  assign c = op == OP_LSR ? a[0] : alu_c;
  // bi is the operand as the ALU saw it, so SBC overflow uses the inverted M
  assign v = (op == OP_ADC || op == OP_SBC) && a[7] == bi[7] && y[7] != a[7];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/DONE execute-stage sequencer driving the 6502 alu and owning P.
// Define ALU_SEQ_BCD_EN to drive alu_BCD from P.D for ADC/SBC; otherwise alu_BCD is tied 0.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] P_RESET = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [7:0] op_a,
  input  logic [7:0] op_m,
  output logic [2:0] alu_ctrl,
  output logic [7:0] alu_AI,
  output logic [7:0] alu_BI,
  output logic       alu_carry,
  output logic       alu_BCD,
  input  logic [7:0] alu_Y,
  input  logic [7:0] alu_flags,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_we,
  output logic [7:0] p_reg,
  input  logic       p_load,
  input  logic [7:0] p_load_data
);
  state_t state;
  logic [2:0] op_q;
  logic [7:0] a_q, m_q, p_q;
  logic exec, arith, n, z, v, c, unused;
  assign exec = state == S_EXEC;
  assign arith = op_q == OP_ADC || op_q == OP_SBC;
  assign op_ready = state == S_IDLE && !p_load;
  assign p_reg = p_q | (8'h01 << P_UNUSED);
  assign unused = ^alu_flags[7:1];
`ifdef ALU_SEQ_BCD_EN
  assign alu_BCD = exec && arith && p_q[P_BCD];
`else
  assign alu_BCD = 1'b0;
`endif
  always_comb begin
    alu_ctrl = ALU_SUM;
    alu_AI = 8'h00;
    alu_BI = 8'h00;
    alu_carry = 1'b0;
    if (exec) begin
      case (op_q)
        OP_ADC, OP_SBC, OP_CMP: begin
          alu_AI = a_q;
          alu_BI = op_q == OP_ADC ? m_q : ~m_q;
          alu_carry = op_q == OP_CMP || p_q[P_CARRY];
        end
        OP_AND: begin alu_ctrl = ALU_AND; alu_AI = a_q; alu_BI = m_q; end
        OP_ORA: begin alu_ctrl = ALU_OR;  alu_AI = a_q; alu_BI = m_q; end
        OP_EOR: begin alu_ctrl = ALU_XOR; alu_AI = a_q; alu_BI = m_q; end
        OP_LSR: begin alu_ctrl = ALU_SR;  alu_AI = a_q; end
        default: ;
      endcase
    end
  end
  alu_seq_flags u_flags (
    .op(op_q), .a(a_q), .bi(alu_BI), .y(alu_Y), .alu_c(alu_flags[0]),
    .n(n), .z(z), .v(v), .c(c)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      p_q <= P_RESET;
      op_q <= OP_ADC;
      a_q <= 8'h00;
      m_q <= 8'h00;
      res_valid <= 1'b0;
      res_data <= 8'h00;
      res_we <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (p_load) p_q <= p_load_data;
          else if (op_valid) begin
            op_q <= op_code;
            a_q <= op_a;
            m_q <= op_m;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q != OP_RSV) begin
            p_q[P_NEG] <= n;
            p_q[P_ZERO] <= z;
          end
          if (arith || op_q == OP_CMP || op_q == OP_LSR) p_q[P_CARRY] <= c;
          if (arith) p_q[P_OVF] <= v;
          res_data <= alu_Y;
          res_we <= op_q != OP_CMP && op_q != OP_RSV;
          res_valid <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Execute-stage sequencer placed directly upstream of the 6502 `alu`: accepts one arithmetic/logic micro-op from decode, drives the ALU control and operand inputs, and consumes `alu_Y` and `alu_flags`. It owns the processor status register P and computes the N, Z, V and C flags itself from operands and `alu_Y`. It then returns a registered result with an accumulator write-enable.

## Interface
- `P_RESET`, default 8'h24: P value on reset (I=1, bit 5=1).
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  micro-op request.
- `op_ready`  out  1  high only in IDLE with `p_load`=0.
- `op_code`  in  3  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 LSR, 7 reserved.
- `op_a`  in  8  accumulator operand.
- `op_m`  in  8  memory/immediate operand.
- `alu_ctrl`  out  3  SUM=0, OR=1, XOR=2, AND=3, SR=4.
- `alu_AI`, `alu_BI`  out  8 each  ALU operands.
- `alu_carry`  out  1  ALU carry in.
- `alu_BCD`  out  1  ALU decimal mode.
- `alu_Y`  in  8  ALU result.
- `alu_flags`  in  8  ALU flags; only bit 0 (carry) is used.
- `res_valid`  out  1  one-cycle result strobe.
- `res_data`  out  8  registered result.
- `res_we`  out  1  accumulator write-enable, qualified by `res_valid`.
- `p_reg`  out  8  status register.
- `p_load`  in  1  load P (PLP/RTI/SEC/CLC path).
- `p_load_data`  in  8  value to load into P.

## Operation
- States: IDLE → EXEC → DONE → IDLE.
  - IDLE→EXEC: on `op_valid && op_ready`; latches `op_code`, `op_a`, `op_m`.
  - EXEC→DONE: always after one cycle.
  - DONE→IDLE: always after one cycle.
- ALU drive in EXEC. Outputs are combinational from the latched registers:
  - ADC: SUM, AI=A, BI=M, carry=P.C.
  - SBC: SUM, AI=A, BI=~M, carry=P.C.
  - CMP: SUM, AI=A, BI=~M, carry=1.
  - AND/ORA/EOR: AND/OR/XOR with AI=A, BI=M, carry=0.
  - LSR: SR with AI=A, BI=0, carry=0.
  - Reserved opcode 7 and all non-EXEC states: SUM with 0/0/0.
- Flags, computed from `alu_Y` at the end of EXEC:
  - N=Y[7]; Z=(Y==0).
  - C: `alu_flags[0]` for ADC/SBC/CMP; A[0] for LSR.
  - V = (A[7]==BI[7]) && (Y[7]!=A[7]) for ADC/SBC only, using BI after inversion.
- P bits updated per opcode; all other bits hold:
  - ADC/SBC: NVZC.
  - CMP: NZC.
  - AND/ORA/EOR: NZ.
  - LSR: NZC.
  - Reserved: none.
- P rules:
  - P[5] always reads 1, regardless of any load.
  - `p_load` is honoured only in IDLE and has priority over `op_valid`. `op_ready` drops for that cycle; the op is accepted the next cycle if still valid.
  - `p_load` is ignored in EXEC and DONE.
- Result:
  - `res_data` = registered Y.
  - `res_we` = 1 for ADC/SBC/AND/ORA/EOR/LSR; 0 for CMP and reserved.
- Reset values:
  - State IDLE, `p_reg`=P_RESET.
  - `res_valid`=0, `res_data`=0, `res_we`=0.
  - `op_ready`=1 after reset deasserts.
  - ALU drive SUM/0/0/0.
- Reset mid-operation: the op is discarded, no `res_valid` pulse, P=P_RESET.

## Timing
- Cycle 0: handshake edge. Cycle 1: EXEC, ALU driven. Cycle 2: DONE, with `res_valid`=1 and P already updated.
- Throughput: one op per 3 cycles; `op_ready`=0 in EXEC and DONE.
- `res_data`/`res_we` hold their values until the next DONE.
- All arithmetic is 8-bit; carry is taken only from the ALU's 9th bit.

## Configuration
- `ALU_SEQ_BCD_EN` defined: `alu_BCD` = P.D during EXEC for ADC/SBC, otherwise 0.
- Not defined: `alu_BCD` tied 0.
- Either way, the D bit is stored and loaded normally and flag computation is binary.

## Structure
- Package `alu_seq_pkg` holds:
  - op-code constants;
  - ALU control codes (shared with `alu`);
  - P bit indices (NEG 7, OVF 6, UNUSED 5, BREAK 4, BCD 3, IRQ 2, ZERO 1, CARRY 0);
  - the state enum.
- Sub-module `alu_seq_flags`: combinational N/Z/V/C computation, instantiated once.

## Test plan
- P=8'h24, ADC A=8'h50 M=8'h50 → cycle-2 `res_valid`, `res_data`=8'hA0, `res_we`=1, P=8'hE4.
- `p_load` 8'h25, then SBC A=8'h05 M=8'h05 → ALU sees BI=8'hFA, carry 1; `res_data`=8'h00, P=8'h27.
- P=8'h24, CMP A=8'h10 M=8'h20 → `res_we`=0, C=0, N=1, Z=0, V unchanged, P=8'hA4.
- LSR A=8'h01 → `res_data`=8'h00, C=1, Z=1, N=0.
- `p_load`=1 with `op_valid`=1 in IDLE → P loaded, `op_ready`=0, op accepted the following cycle.
- Reset pulse during EXEC → IDLE, P=8'h24, no `res_valid`.
- With `ALU_SEQ_BCD_EN` and P.D=1, ADC → `alu_BCD`=1 in EXEC; without the macro → `alu_BCD`=0.
